lsu_mem_master: RTL

Multi-cycle load/store initiator sitting between the core's memory stage and the word-addressed data memory. It accepts one byte, halfword or word load/store request at a time. It drives the memory's `mem_read`/`mem_write`/`addr`/`write_data` interface and returns sign- or zero-extended load data. Sub-word stores are done as read-modify-write because the memory only writes whole words.

---
 rtl/lsu_mem_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide data memory; sub-word stores use RMW.
// Optional misalignment/reserved-size trapping: define LSU_MISALIGN_TRAP_EN.
module lsu_mem_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  state_e      state_q;
  logic        ready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        rerr_q;
  logic        mrd_q;
  logic        mwr_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;
  logic [1:0]  addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic acc_err;
  logic acc_sub;
  logic acc_rd;
  logic acc_wr;

`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_err = (req_size == 2'b11)
                || (req_size == SZ_H && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign acc_err = 1'b0;
`endif

  assign acc_sub = (req_size == SZ_B) || (req_size == SZ_H);
  assign acc_rd  = !acc_err && (!req_we || acc_sub);
  assign acc_wr  = !acc_err && req_we && !acc_sub;

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  a,
    input logic [1:0]  sz,
    input logic        u
  );
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {a, 3'b000};
    h  = a[1] ? w[31:16] : w[15:0];
    unique case (sz)
      SZ_B:    load_ext = {{24{~u & sh[7]}}, sh[7:0]};
      SZ_H:    load_ext = {{16{~u & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [15:0] d,
    input logic [1:0]  a,
    input logic [1:0]  sz
  );
    logic [31:0] msk;
    logic [31:0] dat;
    msk = 32'h0000_00FF << {a, 3'b000};
    dat = {24'h0, d[7:0]} << {a, 3'b000};
    unique case (sz)
      SZ_B:    merge = (w & ~msk) | dat;
      SZ_H:    merge = a[1] ? {d, w[15:0]}
                            : {w[31:16], d};
      default: merge = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            addr_q  <= req_addr[1:0];
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
            unique case (1'b1)
              acc_err: begin
                state_q  <= RESP;
                rvalid_q <= 1'b1;
                rerr_q   <= 1'b1;
                rdata_q  <= '0;
              end
              acc_rd: begin
                state_q <= RD;
                mrd_q   <= 1'b1;
                maddr_q <= {req_addr[31:2], 2'b00};
              end
              acc_wr: begin
                state_q  <= WR;
                mwr_q    <= 1'b1;
                maddr_q  <= {req_addr[31:2], 2'b00};
                mwdata_q <= req_wdata;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        RD: begin
          mrd_q <= 1'b0;
          if (we_q) begin
            state_q  <= WR;
            mwr_q    <= 1'b1;
            mwdata_q <= merge(mem_rdata, wdata_q,
                              addr_q, size_q);
          end else begin
            state_q  <= RESP;
            maddr_q  <= '0;
            rvalid_q <= 1'b1;
            rdata_q  <= load_ext(mem_rdata, addr_q,
                                 size_q, uns_q);
          end
        end
        WR: begin
          state_q  <= RESP;
          mwr_q    <= 1'b0;
          maddr_q  <= '0;
          mwdata_q <= '0;
          rvalid_q <= 1'b1;
          rdata_q  <= '0;
        end
        RESP: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          rvalid_q <= 1'b0;
          rerr_q   <= 1'b0;
          rdata_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
  assign mem_read   = mrd_q;
  assign mem_write  = mwr_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;

endmodule
